// File: rtl/seg_acc_pkg.sv
// Shared types and constants for the segment accumulator: FSM states,
// seven-segment codes (gfedcba, active-high) and the overflow threshold helper.
package seg_acc_pkg;

    typedef enum logic [1:0] {
        ACC,
        CONV,
        OUT
    } state_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b011_1111, 7'b000_0110, 7'b101_1011, 7'b100_1111, 7'b110_0110,
        7'b110_1101, 7'b111_1101, 7'b000_0111, 7'b111_1111, 7'b110_1111
    };

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary to DIGITS BCD digits, one shift-add-3 step per cycle.
// Latency: W_SUM cycles after start, done held until the following edge; digits beyond DIGITS wrap (mod 10^DIGITS).
module bin2bcd_seq #(
    parameter  int W_SUM  = 7,
    parameter  int DIGITS = 3,
    localparam int CNTW   = $clog2(W_SUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_SUM-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [W_SUM-1:0]           sh_q;
    logic [CNTW-1:0]            cnt_q;
    logic [4*DIGITS-1:0]        adj;
    logic [4*DIGITS+W_SUM-1:0]  shifted;

    assign done = busy && (cnt_q == '0);

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Carry out of the top digit is dropped, so the result is the value mod 10^DIGITS.
    assign shifted = {adj, sh_q} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt_q <= '0;
            sh_q  <= '0;
            bcd   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt_q <= CNTW'(W_SUM);
            sh_q  <= bin;
            bcd   <= '0;
        end else if (busy) begin
            if (cnt_q == '0) begin
                busy <= 1'b0;
            end else begin
                {bcd, sh_q} <= shifted;
                cnt_q       <= cnt_q - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_accumulator_axis.sv
// AXIS window accumulator with DIGITS seven-segment output; SEG_ACC_BLANK_EN blanks leading zeros.
// Latency: closing beat at edge T gives m_valid at edge T+W_SUM+1; s_ready is low from close until after the output handshake.
module seg_accumulator_axis
    import seg_acc_pkg::*;
#(
    parameter  int WIDTH     = 3,
    parameter  int MAX_STEPS = 10,
    parameter  int DIGITS    = 3,
    localparam int W_SUM     = WIDTH + $clog2(MAX_STEPS),
    localparam int CW        = $clog2(MAX_STEPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CW-1:0]         cfg_steps,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DIGITS*7-1:0]   m_data,
    output logic [W_SUM-1:0]      m_sum,
    output logic [CW-1:0]         m_count,
    output logic                  m_ovf
);

    localparam logic [63:0] OVF_LIM = pow10(DIGITS) - 64'd1;
`ifdef SEG_ACC_BLANK_EN
    localparam logic [DIGITS*7-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_LUT[0]};
`else
    localparam logic [DIGITS*7-1:0] SEG_RESET = {DIGITS{SEG_LUT[0]}};
`endif

    state_t                state;
    logic [W_SUM-1:0]      sum_q, sum_nxt;
    logic [CW-1:0]         count_q, count_nxt, steps_q, steps_eff;
    logic                  accept, close;
    logic                  conv_busy, conv_done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS*7-1:0]   seg_nxt;

    assign s_ready = (state == ACC) && !rst;
    assign accept  = s_valid && s_ready;

    // count_q == 0 marks the first beat of a window: load instead of add, latch the clamped length.
    always_comb begin
        steps_eff = steps_q;
        count_nxt = count_q + CW'(1);
        sum_nxt   = sum_q + W_SUM'(s_data);
        if (count_q == '0) begin
            count_nxt = CW'(1);
            sum_nxt   = W_SUM'(s_data);
            if (cfg_steps == '0)                 steps_eff = CW'(1);
            else if (cfg_steps > CW'(MAX_STEPS)) steps_eff = CW'(MAX_STEPS);
            else                                 steps_eff = cfg_steps;
        end
    end

    assign close = accept && ((count_nxt == steps_eff) || s_last);

    bin2bcd_seq #(
        .W_SUM  (W_SUM),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (close && !conv_busy),
        .bin   (sum_nxt),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

`ifdef SEG_ACC_BLANK_EN
    logic lead_zero;
`endif

    always_comb begin
        seg_nxt = '0;
`ifdef SEG_ACC_BLANK_EN
        lead_zero = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seg_nxt[7*i +: 7] = SEG_LUT[bcd[4*i +: 4]];
`ifdef SEG_ACC_BLANK_EN
            if (i != 0 && lead_zero && bcd[4*i +: 4] == 4'd0) seg_nxt[7*i +: 7] = SEG_BLANK;
            else lead_zero = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACC;
            sum_q   <= '0;
            count_q <= '0;
            steps_q <= '0;
            m_valid <= 1'b0;
            m_data  <= SEG_RESET;
            m_sum   <= '0;
            m_count <= '0;
            m_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        sum_q   <= sum_nxt;
                        count_q <= count_nxt;
                        steps_q <= steps_eff;
                        if (close) state <= CONV;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        m_valid <= 1'b1;
                        m_data  <= seg_nxt;
                        m_sum   <= sum_q;
                        m_count <= count_q;
                        m_ovf   <= 64'(sum_q) > OVF_LIM;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        count_q <= '0;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
